word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
Consumes words from a single_word_buffer-style holding register and emits them as narrower chunks, LSB chunk first, one chunk per enable pulse.
The enable pulse normally comes from clock_divider, for example one dibit every 4 clocks for RMII-rate transmit.
It sits between a word source and the bit-level line driver.
Back-to-back words are serialized with no gap in chunk slots.

Parameters:
IN_WIDTH, 8, width of an input word; must be a positive multiple of OUT_WIDTH
OUT_WIDTH, 2, width of each output chunk
N (localparam), IN_WIDTH/OUT_WIDTH, chunks per word; N=1 is legal
CNT_W (localparam), clog2(N) (minimum 1), width of the chunk counter

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
in_empty  input  1  upstream buffer empty flag; 0 means in_data holds a valid word
in_data  input  IN_WIDTH  upstream word
in_clear  output  1  combinational; high for exactly the cycle a word is accepted; drives the buffer's clear
out_en  input  1  chunk-slot strobe; the current chunk is consumed on any cycle with out_en=1 and out_valid=1
flush  input  1  synchronous abort of the word in flight
out_valid  output  1  registered; a chunk is presented on out_data
out_data  output  OUT_WIDTH  current chunk, equal to shift[OUT_WIDTH-1:0]
out_last  output  1  out_valid and the current chunk is the final chunk of its word
idle  output  1  state==IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, shift=0, cnt=0, out_valid=0.
  - Consequently out_data=0, out_last=0, idle=1.
  - in_clear is gated low while rst=1, regardless of in_empty.
- State IDLE:
  - Condition load = !in_empty && !flush.
  - On load: shift<=in_data, cnt<=0, state<=SHIFT, in_clear=1 that cycle.
  - out_en is ignored in IDLE.
  - Latency from in_empty falling to out_valid rising is 1 cycle.
- State SHIFT (out_valid=1):
  - Without out_en: hold shift and cnt.
  - out_en with cnt<N-1: shift<=shift>>OUT_WIDTH (zero-fill), cnt<=cnt+1.
  - out_en with cnt==N-1 (last chunk) and !in_empty: reload shift<=in_data, cnt<=0, stay in SHIFT, in_clear=1 that cycle. No idle slot is inserted.
  - out_en with cnt==N-1 and in_empty: state<=IDLE, shift<=0.
- in_clear accounting:
  - Asserted only on an accepted load, at most one per word, never in two consecutive cycles for the same word.
  - The buffer gives inclk priority over clear, so a word written in the same cycle as in_clear is not lost.
  - in_clear must not depend on out_en except through the last-chunk reload condition above.
- flush:
  - Takes priority over everything: state<=IDLE, cnt<=0, shift<=0, in_clear=0.
  - A pending upstream word is left in the buffer and loads on the first cycle after flush deasserts.
- out_last = (state==SHIFT) && (cnt==N-1). For N=1, every valid chunk is last.
- cnt width is sized to hold N-1; no wrap beyond N-1 is ever reached.
- in_data is sampled only on load cycles; changes at other times have no effect.
- Async reset mid-word discards the in-flight word; after release, behaviour matches post-reset.

Test Plan:
- Single word:
  - Stimulus: IN=8, OUT=2; in_data=0xB4 with in_empty falling; out_en every 4th cycle.
  - Required: in_clear high for 1 cycle; out_valid next cycle; chunks 0,1,3,2; out_last on the 4th chunk; back to IDLE after the 4th out_en.
- Back-to-back words:
  - Stimulus: 0xB4 then 0x5A presented before the last out_en of the first word.
  - Required: 8 consecutive valid chunks 0,1,3,2,2,2,1,1; out_valid never drops; two in_clear pulses total.
- Stall:
  - Stimulus: out_en held 0 for 20 cycles mid-word.
  - Required: out_data and cnt constant; no in_clear.
- Flush:
  - Stimulus: flush after the 2nd chunk, with upstream holding 0x3C.
  - Required: out_valid 0 the next cycle; 0x3C loads the cycle after flush falls; chunks 0,3,3,0.
- Reset mid-word:
  - Stimulus: async rst pulse between clock edges.
  - Required: out_valid and out_data go to 0 immediately; in_clear stays 0 while rst=1.
- N=1 configuration:
  - Stimulus: IN=OUT=4; words 0x9 and 0x6 back-to-back.
  - Required: out_last high on every chunk; outputs 9 then 6 on consecutive out_en pulses.

Source files
------------

// File: rtl/word_serializer_if.sv
// Handshake bundle between a word buffer, the serializer and the chunk sink.
// slave: the serializer side. master: the environment (buffer + line driver).
interface word_serializer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2
);
  logic                 in_empty;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_clear;
  logic                 out_en;
  logic                 flush;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 idle;

  modport slave (
    input  in_empty, in_data, out_en, flush,
    output in_clear, out_valid, out_data, out_last, idle
  );

  modport master (
    output in_empty, in_data, out_en, flush,
    input  in_clear, out_valid, out_data, out_last, idle
  );
endinterface

// File: rtl/word_serializer.sv
// Word-to-chunk serializer: takes a word from an upstream holding register and
// emits it LSB chunk first, one chunk per out_en slot. The next word is pulled
// in on the last chunk's slot so back-to-back words have no empty slot.
module word_serializer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2
) (
  input logic              clk,
  input logic              rst,
  word_serializer_if.slave bus
);
  localparam int N     = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_n;
  logic [IN_WIDTH-1:0] shift, shift_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                load;

  // State, shift register and chunk counter; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: flush wins, otherwise load from idle or advance/reload per slot.
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    load    = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
      shift_n = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.in_empty) begin
            load    = 1'b1;
            shift_n = bus.in_data;
            cnt_n   = '0;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.out_en) begin
            if (cnt == LAST) begin
              if (!bus.in_empty) begin
                // Reload in the last chunk's slot: no gap between words.
                load    = 1'b1;
                shift_n = bus.in_data;
                cnt_n   = '0;
              end else begin
                state_n = IDLE;
                shift_n = '0;
                cnt_n   = '0;
              end
            end else begin
              shift_n = shift >> OUT_WIDTH;
              cnt_n   = cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Clear is gated by reset so the buffer never loses a word while we are held.
  assign bus.in_clear  = load & ~rst;
  assign bus.out_valid = (state == SHIFT);
  assign bus.out_data  = shift[OUT_WIDTH-1:0];
  assign bus.out_last  = (state == SHIFT) && (cnt == LAST);
  assign bus.idle      = (state == IDLE);
endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: an 8->2 instance (4 chunks/word) and a 4->4 instance
// (one chunk/word). Each accepted word is split into its expected chunks by
// plain arithmetic and queued; negedge monitors compare the DUT outputs.
module tb_word_serializer;
  localparam int NA = 4, OA = 2;
  localparam int NB = 1, OB = 4;

  typedef struct {
    logic [7:0] d;
    bit         last;
  } chunk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_serializer_if #(.IN_WIDTH(8), .OUT_WIDTH(2)) ifa();
  word_serializer_if #(.IN_WIDTH(4), .OUT_WIDTH(4)) ifb();

  word_serializer #(.IN_WIDTH(8), .OUT_WIDTH(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  word_serializer #(.IN_WIDTH(4), .OUT_WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  chunk_t     qa[$], qb[$];
  logic [7:0] log_a[$], log_b[$];
  bit         buf_full_a = 0, buf_full_b = 0;
  logic [7:0] buf_a = '0;
  logic [3:0] buf_b = '0;
  bit         exp_clr_a = 0, exp_clr_b = 0;
  int         clr_cnt_a = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus for instance A plus the reference-model update.
  task automatic step_a(input bit en, input bit fl, input bit wr, input logic [7:0] wd);
    chunk_t c;
    if (wr && !buf_full_a) begin
      buf_full_a = 1;
      buf_a      = wd;
    end
    ifa.out_en   = en;
    ifa.flush    = fl;
    ifa.in_empty = !buf_full_a;
    ifa.in_data  = buf_full_a ? buf_a : 8'($urandom);
    // A word is taken when nothing is left in flight after this slot.
    exp_clr_a = buf_full_a && !fl && (qa.size() == 0 || (en && qa.size() == 1));
    @(posedge clk);
    if (fl) qa.delete();
    else begin
      if (en && qa.size() != 0) void'(qa.pop_front());
      if (exp_clr_a) begin
        for (int k = 0; k < NA; k++) begin
          c.d    = 8'((int'(buf_a) >> (k * OA)) & ((1 << OA) - 1));
          c.last = (k == NA - 1);
          qa.push_back(c);
        end
        buf_full_a = 0;
      end
    end
    #1;
  endtask

  task automatic step_b(input bit en, input bit fl, input bit wr, input logic [3:0] wd);
    chunk_t c;
    if (wr && !buf_full_b) begin
      buf_full_b = 1;
      buf_b      = wd;
    end
    ifb.out_en   = en;
    ifb.flush    = fl;
    ifb.in_empty = !buf_full_b;
    ifb.in_data  = buf_full_b ? buf_b : 4'($urandom);
    exp_clr_b = buf_full_b && !fl && (qb.size() == 0 || (en && qb.size() == 1));
    @(posedge clk);
    if (fl) qb.delete();
    else begin
      if (en && qb.size() != 0) void'(qb.pop_front());
      if (exp_clr_b) begin
        for (int k = 0; k < NB; k++) begin
          c.d    = 8'((int'(buf_b) >> (k * OB)) & ((1 << OB) - 1));
          c.last = (k == NB - 1);
          qb.push_back(c);
        end
        buf_full_b = 0;
      end
    end
    #1;
  endtask

  // Monitor A: outputs must track the head of the expected-chunk queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_valid", ifa.out_valid, qa.size() != 0);
      chk("a_idle", ifa.idle, qa.size() == 0);
      chk("a_clear", ifa.in_clear, exp_clr_a);
      if (qa.size() != 0) begin
        chk("a_data", ifa.out_data, qa[0].d);
        chk("a_last", ifa.out_last, qa[0].last);
      end else begin
        chk("a_data_idle", ifa.out_data, 0);
        chk("a_last_idle", ifa.out_last, 0);
      end
      if (ifa.in_clear) clr_cnt_a++;
      if (ifa.out_valid && ifa.out_en && !ifa.flush) log_a.push_back(8'(ifa.out_data));
    end
  end

  // Monitor B: single-chunk words, so every valid chunk must be last.
  always @(negedge clk) begin
    if (!rst) begin
      chk("b_valid", ifb.out_valid, qb.size() != 0);
      chk("b_clear", ifb.in_clear, exp_clr_b);
      if (qb.size() != 0) begin
        chk("b_data", ifb.out_data, qb[0].d);
        chk("b_last", ifb.out_last, qb[0].last);
      end
      if (ifb.out_valid && ifb.out_en && !ifb.flush) log_b.push_back(8'(ifb.out_data));
    end
  end

  int exp_single[4] = '{0, 1, 3, 2};
  int exp_b2b[8]    = '{0, 1, 3, 2, 2, 2, 1, 1};
  int exp_flush[4]  = '{0, 3, 3, 0};
  int exp_n1[2]     = '{9, 6};

  initial begin
    int c0;
    ifa.out_en = 0; ifa.flush = 0; ifa.in_empty = 0; ifa.in_data = 8'hAA;
    ifb.out_en = 0; ifb.flush = 0; ifb.in_empty = 0; ifb.in_data = 4'hA;
    #3;
    // Reset state; in_clear held low even with a word upstream.
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_data", ifa.out_data, 0);
    chk("rst_last", ifa.out_last, 0);
    chk("rst_idle", ifa.idle, 1);
    chk("rst_clear", ifa.in_clear, 0);
    chk("rst_clear_b", ifb.in_clear, 0);
    ifa.in_empty = 1;
    ifb.in_empty = 1;
    #4 rst = 0;

    // Single word, one slot every 4 clocks.
    log_a.delete(); clr_cnt_a = 0;
    step_a(0, 0, 1, 8'hB4);
    for (int i = 0; i < 16; i++) step_a(i % 4 == 3, 0, 0, 8'h00);
    chk("single_count", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) chk("single_chunk", log_a[i], exp_single[i]);
    chk("single_clears", clr_cnt_a, 1);

    // Back-to-back words: second word offered while the first is in flight.
    log_a.delete(); clr_cnt_a = 0;
    step_a(0, 0, 1, 8'hB4);
    for (int i = 0; i < 36; i++) step_a(i % 4 == 3, 0, i == 2, 8'h5A);
    chk("b2b_count", log_a.size(), 8);
    for (int i = 0; i < 8 && i < log_a.size(); i++) chk("b2b_chunk", log_a[i], exp_b2b[i]);
    chk("b2b_clears", clr_cnt_a, 2);

    // Stall mid-word: no slots for 20 cycles.
    step_a(0, 0, 1, 8'hE1);
    step_a(1, 0, 0, 8'h00);
    c0 = clr_cnt_a;
    repeat (20) step_a(0, 0, 0, 8'h00);
    chk("stall_clears", clr_cnt_a - c0, 0);
    repeat (3) step_a(1, 0, 0, 8'h00);

    // Flush after the 2nd chunk with 0x3C waiting upstream.
    log_a.delete();
    step_a(0, 0, 1, 8'hE1);
    step_a(1, 0, 0, 8'h00);
    step_a(1, 0, 1, 8'h3C);
    step_a(0, 1, 0, 8'h00);
    step_a(0, 0, 0, 8'h00);
    repeat (4) step_a(1, 0, 0, 8'h00);
    chk("flush_count", log_a.size(), 6);
    for (int i = 0; i < 4 && i + 2 < log_a.size(); i++) chk("flush_chunk", log_a[i+2], exp_flush[i]);

    // Async reset between edges with a word in flight and one pending.
    step_a(0, 0, 1, 8'hC3);
    step_a(1, 0, 0, 8'h00);
    step_a(0, 0, 1, 8'h99);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", ifa.out_valid, 0);
    chk("mid_rst_data", ifa.out_data, 0);
    chk("mid_rst_clear", ifa.in_clear, 0);
    qa.delete();
    @(posedge clk);
    #2;
    chk("mid_rst_clear_hold", ifa.in_clear, 0);
    rst = 0;
    repeat (6) step_a(1, 0, 0, 8'h00);

    // Randomized traffic on A.
    repeat (3000) step_a($urandom % 3 == 0, $urandom % 30 == 0, $urandom % 2 == 1, 8'($urandom));
    for (int i = 0; i < 40 && (buf_full_a || qa.size() != 0); i++) step_a(1, 0, 0, 8'h00);

    // One chunk per word: 0x9 then 0x6 on consecutive slots.
    log_b.delete();
    step_b(0, 0, 1, 4'h9);
    step_b(1, 0, 1, 4'h6);
    step_b(1, 0, 0, 4'h0);
    step_b(0, 0, 0, 4'h0);
    chk("n1_count", log_b.size(), 2);
    for (int i = 0; i < 2 && i < log_b.size(); i++) chk("n1_chunk", log_b[i], exp_n1[i]);

    repeat (2000) step_b($urandom % 2 == 1, $urandom % 25 == 0, $urandom % 2 == 1, 4'($urandom));
    for (int i = 0; i < 40 && (buf_full_b || qb.size() != 0); i++) step_b(1, 0, 0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
